// File: rtl/pcie_hcmd_sq_req_mo.sv
// NVMe SQ command fetch requester with a local tag pool.
// One MRd per command; out-of-order completions free tags.
module pcie_hcmd_sq_req_mo #(
  parameter int C_PCIE_ADDR_WIDTH = 48,
  parameter int P_SLOT_TAG_WIDTH  = 10,
  parameter int P_QID_WIDTH       = 4,
  parameter int P_TAG_BITS        = 3,
  parameter int P_TAG_PREFIX      = 0,
  parameter int P_CMD_DW          = 16
) (
  input  logic                         pcie_user_clk,
  input  logic                         pcie_user_rst_n,
  input  logic                         sq_req_en,
  input  logic                         arb_sq_rdy,
  input  logic [P_QID_WIDTH-1:0]       sq_qid,
  input  logic [C_PCIE_ADDR_WIDTH-3:0] hcmd_pcie_addr,
  output logic                         sq_hcmd_ack,
  input  logic                         hcmd_slot_rdy,
  input  logic [P_SLOT_TAG_WIDTH-1:0]  hcmd_slot_tag,
  output logic                         hcmd_slot_alloc_en,
  output logic                         pcie_sq_cmd_fifo_wr_en,
  output logic [P_TAG_BITS+P_QID_WIDTH+P_SLOT_TAG_WIDTH-1:0]
                                       pcie_sq_cmd_fifo_wr_data,
  input  logic                         pcie_sq_cmd_fifo_full_n,
  output logic                         pcie_sq_rx_tag_alloc,
  output logic [7:0]                   pcie_sq_rx_alloc_tag,
  output logic [10:0]                  pcie_sq_rx_tag_alloc_len,
  input  logic                         pcie_sq_rx_tag_full_n,
  input  logic                         pcie_sq_rx_fifo_full_n,
  input  logic                         sq_tag_release,
  input  logic [P_TAG_BITS-1:0]        sq_tag_release_tag,
  output logic                         sq_tag_release_err,
  output logic                         tx_mrd_req,
  output logic [7:0]                   tx_mrd_tag,
  output logic [12:2]                  tx_mrd_len,
  output logic [C_PCIE_ADDR_WIDTH-3:0] tx_mrd_addr,
  input  logic                         tx_mrd_req_ack,
  output logic [P_TAG_BITS:0]          sq_outstanding_cnt,
  output logic                         sq_req_idle
);

  localparam int NT = 1 << P_TAG_BITS;
  localparam int PW = 8 - P_TAG_BITS;
  localparam int AW = C_PCIE_ADDR_WIDTH - 2;
  localparam int CW = P_TAG_BITS + 1;
  localparam logic [PW-1:0] PREFIX = PW'(P_TAG_PREFIX);
  localparam logic [10:0]   LEN    = 11'(P_CMD_DW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_INFO,
    S_CHECK,
    S_MRD_REQ,
    S_MRD_ACK
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [NT-1:0]               busy_q;
  logic [NT-1:0]               busy_d;
  logic [NT-1:0]               set_vec;
  logic [NT-1:0]               clr_vec;
  logic [CW-1:0]               cnt_q;
  logic [P_TAG_BITS-1:0]       free_tag;
  logic                        any_free;
  logic                        acquire;
  logic                        tx_room;
  logic                        set_en;
  logic                        rel_ok;
  logic                        err_q;
  logic [P_TAG_BITS-1:0]       tag_q;
  logic [P_QID_WIDTH-1:0]      qid_q;
  logic [P_SLOT_TAG_WIDTH-1:0] slot_q;
  logic [AW-1:0]               addr_q;

  // Lowest-index free tag, from the registered bitmap only.
  always_comb begin
    free_tag = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_tag = P_TAG_BITS'(i);
    end
  end

  assign any_free = ~&busy_q;
  assign acquire  = sq_req_en & arb_sq_rdy
                  & hcmd_slot_rdy & any_free;
  assign tx_room  = pcie_sq_cmd_fifo_full_n
                  & pcie_sq_rx_tag_full_n
                  & pcie_sq_rx_fifo_full_n;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (acquire) state_d = S_CMD_INFO;
      S_CMD_INFO: state_d = S_CHECK;
      S_CHECK:    if (tx_room) state_d = S_MRD_REQ;
      S_MRD_REQ:  state_d = S_MRD_ACK;
      S_MRD_ACK:  if (tx_mrd_req_ack) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) state_q <= S_IDLE;
    else                  state_q <= state_d;
  end

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      tag_q  <= '0;
      qid_q  <= '0;
      slot_q <= '0;
      addr_q <= '0;
    end else if (state_q == S_CMD_INFO) begin
      tag_q  <= free_tag;
      qid_q  <= sq_qid;
      slot_q <= hcmd_slot_tag;
      addr_q <= hcmd_pcie_addr;
    end
  end

  // A release aimed at a tag being set this cycle sees it clear: error.
  assign set_en  = (state_q == S_MRD_REQ);
  assign rel_ok  = sq_tag_release & busy_q[sq_tag_release_tag];
  assign set_vec = set_en ? (NT'(1) << tag_q) : '0;
  assign clr_vec = rel_ok ? (NT'(1) << sq_tag_release_tag) : '0;
  assign busy_d  = (busy_q & ~clr_vec) | set_vec;

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= sq_tag_release & ~busy_q[sq_tag_release_tag];
      unique case ({set_en, rel_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign sq_hcmd_ack              = (state_q == S_CMD_INFO);
  assign hcmd_slot_alloc_en       = (state_q == S_CMD_INFO);
  assign pcie_sq_cmd_fifo_wr_en   = set_en;
  assign pcie_sq_rx_tag_alloc     = set_en;
  assign tx_mrd_req               = set_en;
  assign pcie_sq_cmd_fifo_wr_data = {tag_q, qid_q, slot_q};
  assign pcie_sq_rx_alloc_tag     = {PREFIX, tag_q};
  assign tx_mrd_tag               = {PREFIX, tag_q};
  assign pcie_sq_rx_tag_alloc_len = LEN;
  assign tx_mrd_len               = LEN;
  assign tx_mrd_addr              = addr_q;
  assign sq_tag_release_err       = err_q;
  assign sq_outstanding_cnt       = cnt_q;
  assign sq_req_idle = (state_q == S_IDLE) && (cnt_q == '0);

endmodule

// File: tb/tb_pcie_hcmd_sq_req_mo.sv
// Directed bench for pcie_hcmd_sq_req_mo: tag pool, ordering,
// release corner cases, backpressure and mid-flight reset.
module tb_pcie_hcmd_sq_req_mo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sq_req_en;
  logic        arb_sq_rdy;
  logic [3:0]  sq_qid;
  logic [45:0] hcmd_pcie_addr;
  logic        sq_hcmd_ack;
  logic        hcmd_slot_rdy;
  logic [9:0]  hcmd_slot_tag;
  logic        hcmd_slot_alloc_en;
  logic        wr_en;
  logic [16:0] wr_data;
  logic        cmd_full_n;
  logic        rx_tag_alloc;
  logic [7:0]  rx_alloc_tag;
  logic [10:0] rx_alloc_len;
  logic        rx_tag_full_n;
  logic        rx_fifo_full_n;
  logic        rel;
  logic [2:0]  rel_tag;
  logic        rel_err;
  logic        mrd_req;
  logic [7:0]  mrd_tag;
  logic [10:0] mrd_len;
  logic [45:0] mrd_addr;
  logic        mrd_ack;
  logic [3:0]  cnt;
  logic        idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcie_hcmd_sq_req_mo dut (
    .pcie_user_clk            (clk),
    .pcie_user_rst_n          (rst_n),
    .sq_req_en                (sq_req_en),
    .arb_sq_rdy               (arb_sq_rdy),
    .sq_qid                   (sq_qid),
    .hcmd_pcie_addr           (hcmd_pcie_addr),
    .sq_hcmd_ack              (sq_hcmd_ack),
    .hcmd_slot_rdy            (hcmd_slot_rdy),
    .hcmd_slot_tag            (hcmd_slot_tag),
    .hcmd_slot_alloc_en       (hcmd_slot_alloc_en),
    .pcie_sq_cmd_fifo_wr_en   (wr_en),
    .pcie_sq_cmd_fifo_wr_data (wr_data),
    .pcie_sq_cmd_fifo_full_n  (cmd_full_n),
    .pcie_sq_rx_tag_alloc     (rx_tag_alloc),
    .pcie_sq_rx_alloc_tag     (rx_alloc_tag),
    .pcie_sq_rx_tag_alloc_len (rx_alloc_len),
    .pcie_sq_rx_tag_full_n    (rx_tag_full_n),
    .pcie_sq_rx_fifo_full_n   (rx_fifo_full_n),
    .sq_tag_release           (rel),
    .sq_tag_release_tag       (rel_tag),
    .sq_tag_release_err       (rel_err),
    .tx_mrd_req               (mrd_req),
    .tx_mrd_tag               (mrd_tag),
    .tx_mrd_len               (mrd_len),
    .tx_mrd_addr              (mrd_addr),
    .tx_mrd_req_ack           (mrd_ack),
    .sq_outstanding_cnt       (cnt),
    .sq_req_idle              (idle)
  );

  typedef struct {
    logic [3:0]  q;
    logic [45:0] a;
    logic [9:0]  s;
    logic [2:0]  et;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called on a negedge with the DUT idle; ends on a negedge back in IDLE.
  task automatic fetch(input logic [3:0]  q,
                       input logic [45:0] a,
                       input logic [9:0]  s,
                       input logic [2:0]  et,
                       input logic [3:0]  ec,
                       input bit          rl,
                       input logic [2:0]  rt);
    int n;
    sq_qid = q;
    hcmd_pcie_addr = a;
    hcmd_slot_tag = s;
    arb_sq_rdy = 1'b1;
    hcmd_slot_rdy = 1'b1;
    @(negedge clk);
    chk("ack", sq_hcmd_ack, 1);
    chk("alloc_en", hcmd_slot_alloc_en, 1);
    arb_sq_rdy = 1'b0;
    hcmd_slot_rdy = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mrd_req && n < 20);
    chk("mrd_latency", n, 2);
    chk("mrd_tag", mrd_tag, {5'd0, et});
    chk("rx_alloc_tag", rx_alloc_tag, {5'd0, et});
    chk("wr_data", wr_data, {et, q, s});
    chk("mrd_addr", mrd_addr, a);
    chk("wr_en_rx_alloc", {wr_en, rx_tag_alloc}, 2'b11);
    if (rl) begin
      rel = 1'b1;
      rel_tag = rt;
    end
    @(negedge clk);
    rel = 1'b0;
    chk("cnt_after_fetch", cnt, ec);
    chk("mrd_req_one_cycle", mrd_req, 0);
    chk("no_rel_err", rel_err, 0);
    @(negedge clk);
  endtask

  task automatic release_tag(input logic [2:0] t);
    rel = 1'b1;
    rel_tag = t;
    @(negedge clk);
    rel = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int strobes;
    tbl[0] = '{4'd3, 46'h1234_5678_9A0, 10'h2A5, 3'd0, 4'd1};
    tbl[1] = '{4'd1, 46'h0000_0000_010, 10'h001, 3'd1, 4'd2};
    tbl[2] = '{4'd15, 46'h3FFF_FFFF_FFFF, 10'h3FF, 3'd2, 4'd3};
    tbl[3] = '{4'd0, 46'h0AAA_5555_000, 10'h100, 3'd3, 4'd4};
    tbl[4] = '{4'd7, 46'h0000_DEAD_BEE, 10'h0F0, 3'd4, 4'd5};
    tbl[5] = '{4'd8, 46'h2000_0000_001, 10'h155, 3'd5, 4'd6};
    tbl[6] = '{4'd12, 46'h0123_4567_89A, 10'h2AA, 3'd6, 4'd7};
    tbl[7] = '{4'd5, 46'h1111_2222_333, 10'h07E, 3'd7, 4'd8};

    rst_n = 1'b0;
    sq_req_en = 1'b1;
    arb_sq_rdy = 1'b0;
    sq_qid = '0;
    hcmd_pcie_addr = '0;
    hcmd_slot_rdy = 1'b0;
    hcmd_slot_tag = '0;
    cmd_full_n = 1'b1;
    rx_tag_full_n = 1'b1;
    rx_fifo_full_n = 1'b1;
    rel = 1'b0;
    rel_tag = '0;
    mrd_ack = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_idle", idle, 1);
    chk("rst_cnt", cnt, 0);
    chk("rst_strobes",
        {sq_hcmd_ack, hcmd_slot_alloc_en, wr_en,
         rx_tag_alloc, mrd_req, rel_err}, 0);
    chk("rst_tag", mrd_tag, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_addr", mrd_addr, 0);
    chk("mrd_len", mrd_len, 11'h10);
    chk("alloc_len", rx_alloc_len, 11'h10);

    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_strobes", {sq_hcmd_ack, wr_en, mrd_req}, 0);

    // Disabled requester must not accept work.
    sq_req_en = 1'b0;
    arb_sq_rdy = 1'b1;
    hcmd_slot_rdy = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      acks += int'(sq_hcmd_ack);
    end
    arb_sq_rdy = 1'b0;
    hcmd_slot_rdy = 1'b0;
    sq_req_en = 1'b1;
    chk("disabled_no_ack", acks, 0);
    @(negedge clk);

    foreach (tbl[i])
      fetch(tbl[i].q, tbl[i].a, tbl[i].s,
            tbl[i].et, tbl[i].ec, 1'b0, 3'd0);

    // Pool exhausted: the request must be held off.
    arb_sq_rdy = 1'b1;
    hcmd_slot_rdy = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      acks += int'(sq_hcmd_ack);
    end
    arb_sq_rdy = 1'b0;
    hcmd_slot_rdy = 1'b0;
    chk("full_no_ack", acks, 0);
    chk("full_not_idle", idle, 0);
    @(negedge clk);

    release_tag(3'd5);
    chk("rel5_err", rel_err, 0);
    chk("rel5_cnt", cnt, 7);
    fetch(4'd2, 46'h55, 10'h5, 3'd5, 4'd8, 1'b0, 3'd0);

    // Release of tag 2 coincides with setting tag 3.
    release_tag(3'd3);
    chk("rel3_cnt", cnt, 7);
    fetch(4'd9, 46'h99, 10'h9, 3'd3, 4'd7, 1'b1, 3'd2);
    fetch(4'd6, 46'h66, 10'h6, 3'd2, 4'd8, 1'b0, 3'd0);

    release_tag(3'd6);
    chk("rel6_first_err", rel_err, 0);
    chk("rel6_first_cnt", cnt, 7);
    release_tag(3'd6);
    chk("rel6_idle_err", rel_err, 1);
    chk("rel6_idle_cnt", cnt, 7);
    @(negedge clk);
    chk("rel6_err_once", rel_err, 0);
    fetch(4'd4, 46'h44, 10'h4, 3'd6, 4'd8, 1'b0, 3'd0);

    // RX backpressure in CHECK, then a slow TX ack.
    release_tag(3'd0);
    release_tag(3'd1);
    chk("rel01_cnt", cnt, 6);
    rx_fifo_full_n = 1'b0;
    mrd_ack = 1'b0;
    sq_qid = 4'd5;
    hcmd_pcie_addr = 46'h3;
    hcmd_slot_tag = 10'h11;
    arb_sq_rdy = 1'b1;
    hcmd_slot_rdy = 1'b1;
    @(negedge clk);
    chk("bp_ack", sq_hcmd_ack, 1);
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      strobes += int'(wr_en) + int'(mrd_req)
               + int'(rx_tag_alloc) + int'(sq_hcmd_ack);
      if (i == 9) rx_fifo_full_n = 1'b1;
    end
    chk("bp_no_strobes", strobes, 0);
    @(negedge clk);
    chk("bp_mrd_req", mrd_req, 1);
    chk("bp_mrd_tag", mrd_tag, 0);
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      acks += int'(sq_hcmd_ack);
      if (i == 6) begin
        mrd_ack = 1'b1;
        arb_sq_rdy = 1'b0;
        hcmd_slot_rdy = 1'b0;
      end
    end
    chk("slow_ack_no_new_cmd", acks, 0);
    chk("bp_cnt", cnt, 7);
    @(negedge clk);
    chk("bp_back_idle_no_ack", sq_hcmd_ack, 0);
    fetch(4'd1, 46'h11, 10'h1, 3'd1, 4'd8, 1'b0, 3'd0);

    // Fresh pool, three fetches, then reset while in MRD_ACK.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(4'd1, 46'h100, 10'h10, 3'd0, 4'd1, 1'b0, 3'd0);
    fetch(4'd2, 46'h200, 10'h20, 3'd1, 4'd2, 1'b0, 3'd0);
    fetch(4'd3, 46'h300, 10'h30, 3'd2, 4'd3, 1'b0, 3'd0);
    mrd_ack = 1'b0;
    sq_qid = 4'd7;
    hcmd_pcie_addr = 46'h2AAA;
    hcmd_slot_tag = 10'h3FF;
    arb_sq_rdy = 1'b1;
    hcmd_slot_rdy = 1'b1;
    @(negedge clk);
    chk("pre_rst_ack", sq_hcmd_ack, 1);
    arb_sq_rdy = 1'b0;
    hcmd_slot_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_tag", mrd_tag, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes",
        {sq_hcmd_ack, hcmd_slot_alloc_en, wr_en,
         rx_tag_alloc, mrd_req, rel_err}, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_tag", mrd_tag, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_addr", mrd_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mrd_ack = 1'b1;
    @(negedge clk);
    chk("post_mid_rst_strobes", {sq_hcmd_ack, wr_en, mrd_req}, 0);
    fetch(4'd8, 46'h800, 10'h80, 3'd0, 4'd1, 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
